md_issue_ctrl: RTL
==================

# md_issue_ctrl

EX-stage initiator for the `multdiv` HI/LO unit.
- Takes decoded multiply/divide/move instructions from the pipeline and converts them into `start`/`mode`/`we`/`a1` requests toward `multdiv`.
- Tracks in-flight operations, including the start cycle before `busy` rises, and stalls the pipeline on HI/LO conflicts.
- Returns `mfhi`/`mflo` results registered toward the MEM stage.
- Sits between the EX-stage operand forwarding muxes and the `multdiv` instance.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `op_valid`  in  1  EX stage holds an MD-class instruction.
- `op`  in  4  `md_op_t`: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- `rs_val`  in  WIDTH  forwarded rs operand.
- `rt_val`  in  WIDTH  forwarded rt operand.
- `flush`  in  1  EX instruction is being killed (exception/eret).
- `md_busy`, `md_hi`, `md_lo`  in  1/WIDTH/WIDTH  from `multdiv`.
- `md_start`, `md_we`, `md_a1`  out  1 each  to `multdiv`.
- `md_mode`  out  2  to `multdiv`.
- `md_a`, `md_b`  out  WIDTH  to `multdiv`.
- `stall`  out  1  freeze IF/ID/EX, bubble into MEM.
- `rd_valid`  out  1  registered read result valid.
- `rd_data`  out  WIDTH  registered HI/LO value.
- `stall_cnt`  out  32  stall-cycle counter (see Configuration).

## Operation
- States:
  - IDLE: no operation outstanding.
  - LAUNCH: the cycle after `md_start`; `md_busy` is not yet trusted.
  - BUSY: waiting for `md_busy`=0.
- An op is *accepted* when `op_valid & ~flush & ~stall`. All request outputs are combinational on acceptance, otherwise 0.
- `md_a`=`rs_val`, `md_b`=`rt_val` whenever `op_valid`; otherwise 0.
- MULT/MULTU/DIV/DIVU:
  - `md_start`=1 for exactly one cycle.
  - `md_mode` = 0/1/2/3 respectively.
  - Next state is LAUNCH.
- MTHI/MTLO:
  - `md_we`=1 for one cycle; `md_a1`=1 selects HI, `md_a1`=0 selects LO.
  - State unchanged.
- MFHI/MFLO:
  - `rd_data` <= `md_hi`/`md_lo` at the next edge; `rd_valid` <= 1 for one cycle.
- `stall` = `op_valid & ~flush & (state==LAUNCH | (state==BUSY & md_busy))`.
- Transitions:
  - LAUNCH -> BUSY unconditionally.
  - BUSY -> IDLE when `md_busy`=0, unless a new start is accepted in that same cycle (-> LAUNCH). No bubble cycle is inserted.
- `flush`:
  - Suppresses acceptance and stall for the current EX op.
  - Never aborts an in-flight `multdiv` operation; that operation completes normally.
- Divide-by-zero: passed through unchanged; HI/LO result is whatever `multdiv` produces.
- Non-MD ops (`op_valid`=0 or `op`=NONE) never stall.

## Timing
- Reset values: state IDLE, `rd_valid`=0, `rd_data`=0, `stall_cnt`=0. All combinational outputs evaluate to 0 while `clr` is high.
- `clr` asserted mid-operation forces IDLE immediately. `multdiv` shares `clr` and is cleared with it.
- Start-to-read latency: `multdiv` latency + 1 (LAUNCH), with reads accepted in the first cycle `md_busy`=0.
- `rd_data`/`rd_valid` latency is 1 cycle after acceptance.
- Back-to-back MTHI then MFHI: MFHI is accepted the next cycle and returns the written value, because `multdiv` updates HI at that edge.
- Simultaneous `flush` and a stall condition: `flush` wins and `stall` is 0.

## Configuration
- `MD_STALL_CNT_EN` defined:
  - `stall_cnt` increments by 1 on every cycle `stall`=1.
  - Wraps at 2^32.
  - Cleared by `clr`.
- `MD_STALL_CNT_EN` undefined:
  - Counter logic removed; `stall_cnt` tied to 0.

## Structure
- Shared package `md_pkg`:
  - `md_op_t` enum.
  - Mode constants `MD_MODE_MULT`=0, `MD_MODE_MULTU`=1, `MD_MODE_DIV`=2, `MD_MODE_DIVU`=3.
  - `MD_SEL_HI`=1, `MD_SEL_LO`=0.
  - State enum `md_ctl_state_t`.
- One sub-module: `md_op_decode`, combinational `op` -> {is_start, is_move, is_read, mode, a1}. The state machine, read register and counter live in `md_issue_ctrl`.

## Test plan
- MULT, rs=3, rt=2 from IDLE -> `md_start`=1, `md_mode`=0, `md_a`=3, `md_b`=2 for one cycle. A following MFLO stalls through LAUNCH and BUSY, is accepted the first cycle `md_busy`=0, and returns `rd_data`=6 with `rd_valid` one cycle later.
- MTHI rs=15 in IDLE -> `md_we`=1, `md_a1`=1, `md_a`=15, no stall. MFHI next cycle -> `rd_data`=15.
- DIVU issued, then DIV while `md_busy`=1 -> `stall`=1 every waiting cycle. DIV's `md_start` fires in the same cycle `md_busy` falls. `stall_cnt` equals the waiting cycle count with the macro defined, and 0 without it.
- MULT with `flush`=1 -> `md_start`=0, `stall`=0, state stays IDLE.
- `clr` pulsed in BUSY -> state IDLE, `stall`=0, `rd_valid`=0, `stall_cnt`=0. A subsequent MFLO is accepted without stall.
- DIV with rt=0 -> start issued normally; no stall beyond `md_busy`; completion returns to IDLE.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the multdiv issue controller.
// Holds the MD op enum, multdiv mode/select encodings, the controller
// state enum and the decoded-op payload struct.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  localparam logic [1:0] MD_MODE_MULT  = 2'd0;
  localparam logic [1:0] MD_MODE_MULTU = 2'd1;
  localparam logic [1:0] MD_MODE_DIV   = 2'd2;
  localparam logic [1:0] MD_MODE_DIVU  = 2'd3;

  localparam logic MD_SEL_HI = 1'b1;
  localparam logic MD_SEL_LO = 1'b0;

  typedef enum logic [1:0] {
    MD_ST_IDLE   = 2'd0,
    MD_ST_LAUNCH = 2'd1,
    MD_ST_BUSY   = 2'd2
  } md_ctl_state_t;

  // Decoded view of one MD-class op
  typedef struct packed {
    logic       is_start;
    logic       is_move;
    logic       is_read;
    logic [1:0] mode;
    logic       a1;
  } md_dec_t;

endpackage

// File: rtl/md_op_decode.sv
// Combinational decoder: md_op_t -> {is_start, is_move, is_read, mode, a1}.
// Ports:
//   op_i     in  MD op from the EX stage
//   dec_c_o  out decoded fields (unregistered)
module md_op_decode
  import md_pkg::*;
(
  input  md_op_t  op_i,
  output md_dec_t dec_c_o
);

  always_comb begin
    dec_c_o = '0;
    case (op_i)
      MD_MULT:  begin dec_c_o.is_start = 1'b1; dec_c_o.mode = MD_MODE_MULT;  end
      MD_MULTU: begin dec_c_o.is_start = 1'b1; dec_c_o.mode = MD_MODE_MULTU; end
      MD_DIV:   begin dec_c_o.is_start = 1'b1; dec_c_o.mode = MD_MODE_DIV;   end
      MD_DIVU:  begin dec_c_o.is_start = 1'b1; dec_c_o.mode = MD_MODE_DIVU;  end
      MD_MTHI:  begin dec_c_o.is_move  = 1'b1; dec_c_o.a1   = MD_SEL_HI;     end
      MD_MTLO:  begin dec_c_o.is_move  = 1'b1; dec_c_o.a1   = MD_SEL_LO;     end
      MD_MFHI:  begin dec_c_o.is_read  = 1'b1; dec_c_o.a1   = MD_SEL_HI;     end
      MD_MFLO:  begin dec_c_o.is_read  = 1'b1; dec_c_o.a1   = MD_SEL_LO;     end
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage initiator for the multdiv HI/LO unit. Turns decoded MD ops into
// start/mode/we/a1 requests, tracks the in-flight operation (including the
// launch cycle before md_busy is valid), stalls on HI/LO conflicts and
// returns registered mfhi/mflo data toward MEM.
// Ports:
//   clk, clr                 clock, async active-high reset (shared with multdiv)
//   op_valid, op, flush      EX-stage MD instruction, kill
//   rs_val, rt_val           forwarded operands
//   md_busy, md_hi, md_lo    status/results from multdiv
//   md_start, md_we, md_a1, md_mode, md_a, md_b   requests to multdiv (comb)
//   stall                    pipeline freeze (comb)
//   rd_valid, rd_data        registered HI/LO read result
//   stall_cnt                stall-cycle counter, present only with MD_STALL_CNT_EN
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             op_valid,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             md_busy,
  input  logic [WIDTH-1:0] md_hi,
  input  logic [WIDTH-1:0] md_lo,
  output logic             md_start,
  output logic             md_we,
  output logic             md_a1,
  output logic [1:0]       md_mode,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  output logic             stall,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [31:0]      stall_cnt
);

  localparam int unsigned CNT_W = 32;

  md_ctl_state_t    state_q, state_d;
  md_dec_t          dec;
  logic             live_c;
  logic             accept_c;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;

  md_op_decode u_dec (
    .op_i    (op),
    .dec_c_o (dec)
  );

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= MD_ST_IDLE;
    else     state_q <= state_d;
  end

  // Acceptance, stall, multdiv requests and next state
  always_comb begin
    // Non-MD or killed ops never stall; everything is held low during clr
    live_c   = op_valid & ~flush & ~clr & (dec.is_start | dec.is_move | dec.is_read);
    stall    = live_c & ((state_q == MD_ST_LAUNCH) |
                         ((state_q == MD_ST_BUSY) & md_busy));
    accept_c = live_c & ~stall;
    md_start = accept_c & dec.is_start;
    md_mode  = md_start ? dec.mode : 2'b00;
    md_we    = accept_c & dec.is_move;
    md_a1    = md_we & dec.a1;
    md_a     = (op_valid & ~clr) ? rs_val : '0;
    md_b     = (op_valid & ~clr) ? rt_val : '0;
    state_d  = state_q;
    case (state_q)
      MD_ST_IDLE:   if (md_start) state_d = MD_ST_LAUNCH;
      MD_ST_LAUNCH: state_d = MD_ST_BUSY;
      // A start accepted as busy drops chains straight into a new launch
      MD_ST_BUSY: begin
        if (md_start)      state_d = MD_ST_LAUNCH;
        else if (!md_busy) state_d = MD_ST_IDLE;
      end
      default:      state_d = MD_ST_IDLE;
    endcase
  end

  // HI/LO read register toward MEM
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= accept_c & dec.is_read;
      if (accept_c & dec.is_read)
        rd_data_q <= (dec.a1 == MD_SEL_HI) ? md_hi : md_lo;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef MD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Free-running stall counter, wraps naturally
  always_ff @(posedge clk or posedge clr) begin
    if (clr)        stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = CNT_W'(0);
`endif

endmodule
